data_bus_arbiter: RTL and testbench
===================================

# data_bus_arbiter

Two-master arbiter for the shared data-memory/peripheral bus: the single-cycle CPU load/store port (master 0) and a DMA/UART transfer engine (master 1). The block grants one master per cycle, muxes that master's address, write data and strobes onto the bus, and returns read data to it. Master 0 has priority. Master 1 gets aging-based fairness and bounded locked bursts. The CPU stalls its PC while `m0_req && !m0_gnt`.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `MAX_WAIT`, 4, wait-counter value at which a pending m1 request preempts m0 (≥1)
- `BURST_MAX`, 8, maximum consecutive m1 beats honoured under `m1_lock` (≥2, power of two)

Ports:
- `clk` in 1: CPU clock; sole clock
- `reset` in 1: asynchronous, active-high
- `m0_req`, `m0_wr` in 1: CPU access request / write (else read)
- `m0_addr` in AW, `m0_wdata` in DW: CPU address and write data
- `m0_gnt` out 1, `m0_rdata` out DW: grant; read data (0 when not granted)
- `m1_req`, `m1_wr`, `m1_lock` in 1: engine request / write / burst lock
- `m1_addr` in AW, `m1_wdata` in DW
- `m1_gnt` out 1, `m1_rdata` out DW
- `bus_rd`, `bus_wr` out 1: bus read/write strobes
- `bus_addr` out AW, `bus_wdata` out DW
- `bus_rdata` in DW: OR-combined memory/peripheral read data, combinational
- `owner` out 2: 0 idle, 1 m0, 2 m1

## Operation
- Registered state `st` ∈ {IDLE, OWN0, OWN1}. `m0_gnt = (st==OWN0)`, `m1_gnt = (st==OWN1)`, `owner` encodes `st`.
- A beat is a cycle with `req && gnt`.
  - Write commits at the clock edge ending that cycle.
  - Read data (`mX_rdata = bus_rdata`) is valid in that same cycle.
- The requester holds `req` and its signals stable until a beat occurs.
- Bus drive is combinational from `st` and the owner's inputs:
  - `bus_rd = gnt & req & ~wr`; `bus_wr = gnt & req & wr`.
  - `bus_addr` and `bus_wdata` come from the owner; they are 0 in IDLE.
- `wait1`: saturating counter, 0..MAX_WAIT. It increments on each cycle with `m1_req && !m1_gnt` and clears on any cycle with `m1_gnt`.
- `beats`: counter, 0..BURST_MAX-1, saturating. It increments each OWN1 cycle and clears when `st != OWN1`.
- Next state is evaluated every cycle with the current counter values. Priority order:
  1. `st==OWN1 && m1_req && m1_lock && beats < BURST_MAX-1` → OWN1 (locked)
  2. `m1_req && (!m0_req || wait1 >= MAX_WAIT)` → OWN1
  3. `m0_req` → OWN0
  4. otherwise → IDLE
- Handoff between masters has no bubble, e.g. OWN0→OWN1 directly.
- An owner that drops `req` is released at the next edge. There is no bus strobe in the cycle `req` is low.
- The two counters give these guarantees:
  - m1 waits at most MAX_WAIT+1 cycles.
  - m0 waits at most BURST_MAX beats plus one.

## Timing
- Reset values: `st`=IDLE, `wait1`=0, `beats`=0.
  - All outputs are 0: `m0_gnt`, `m1_gnt`, `owner`, `bus_rd`, `bus_wr`, `bus_addr`, `bus_wdata`, `m0_rdata`, `m1_rdata`.
- Grant latency from IDLE: a request at cycle t is granted at t+1.
- An owner that keeps `req` high gets one beat per cycle.
- Simultaneous requests from IDLE: m0 wins unless `wait1 >= MAX_WAIT`.
- Reset asserted mid-transfer:
  - Grants and strobes drop immediately (asynchronous); an in-flight write does not commit.
  - After release, a pending request is granted at the first edge.
- `m1_lock` is ignored when `m0_req` is low; rule 2 keeps m1 anyway.

## Structure
- Package `arb_pkg`:
  - `arb_state_t` enum (ARB_IDLE=0, ARB_OWN0=1, ARB_OWN1=2), whose encoding equals `owner`.
  - Default constants for MAX_WAIT and BURST_MAX.
- Sub-module `sat_counter` (parameter MAX; inputs `inc`, `clr`; output `cnt`): reset to 0, `clr` has priority over `inc`. Instantiated for `wait1` and `beats`.
- Next-state logic and the bus mux live in the top module.

## Test plan
- Reset, no requests → all outputs 0, `owner`=0, for 5 cycles.
- Single write: `m0_req`=1, `m0_wr`=1, `m0_addr`=0x10, `m0_wdata`=0xDEADBEEF at cycle 1.
  - Cycle 2: `m0_gnt`=1, `bus_wr`=1, `bus_addr`=0x10, `bus_wdata`=0xDEADBEEF.
  - A subsequent read of 0x10 returns 0xDEADBEEF on `m0_rdata`.
- Aging: both masters request continuously from cycle 1.
  - Cycles 2–5: m0 granted.
  - Cycle 6: `m1_gnt`=1 for one beat.
  - Cycle 7: m0 granted again.
- Locked burst: `m1_lock`=1 with 12 beats pending; m0 pending from cycle 1; MAX_WAIT=4, BURST_MAX=8.
  - m0 owns cycles 2–5.
  - m1 owns cycles 6–13 (8 consecutive beats).
  - m0 owns cycle 14.
  - m1 resumes no later than cycle 19.
- Release: m0 drops `req` while owner → next cycle `owner`=0, `bus_rd`=`bus_wr`=0.
- Reset pulse mid m1 burst:
  - Same cycle: `m1_gnt`, `bus_wr`, `owner` go to 0; memory is unchanged.
  - After release: counters 0; held `m1_req` is granted one cycle later.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and default tuning constants for the two-master data bus arbiter.
// The state encoding is exported directly on the owner port.
package arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_t;

    localparam int ARB_MAX_WAIT  = 4;
    localparam int ARB_BURST_MAX = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter from 0 to MAX; a clear wins over an increment.
module sat_counter #(
    parameter int MAX = 4,
    localparam int W = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = W'(MAX);

    // Count register: holds at CNT_MAX until cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + W'(1);
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master data bus arbiter: CPU port (m0) has priority, the DMA/UART engine (m1)
// gets aging-based preemption and bounded locked bursts. One grant per cycle.
module data_bus_arbiter
    import arb_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_WAIT  = ARB_MAX_WAIT,
    parameter int BURST_MAX = ARB_BURST_MAX
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_wr,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_wr,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic [DW-1:0] m1_rdata,
    output logic          bus_rd,
    output logic          bus_wr,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic [DW-1:0] bus_rdata,
    output logic [1:0]    owner
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int BW = $clog2(BURST_MAX);
    localparam logic [WW-1:0] WAIT_LIM = WW'(MAX_WAIT);
    localparam logic [BW-1:0] BEAT_LIM = BW'(BURST_MAX - 1);

    arb_state_t    st;
    arb_state_t    nxt_st;
    logic [WW-1:0] wait1;
    logic [BW-1:0] beats;

    assign m0_gnt   = (st == ARB_OWN0);
    assign m1_gnt   = (st == ARB_OWN1);
    assign owner    = st;
    assign m0_rdata = m0_gnt ? bus_rdata : '0;
    assign m1_rdata = m1_gnt ? bus_rdata : '0;

    // Clearing on the edge that grants m1 keeps wait1 at zero for the whole
    // ownership, so a single aged beat cannot re-trigger preemption.
    sat_counter #(.MAX(MAX_WAIT)) u_wait1 (
        .clk   (clk),
        .reset (reset),
        .inc   (m1_req && !m1_gnt),
        .clr   (m1_gnt || (nxt_st == ARB_OWN1)),
        .cnt   (wait1)
    );

    sat_counter #(.MAX(BURST_MAX - 1)) u_beats (
        .clk   (clk),
        .reset (reset),
        .inc   (st == ARB_OWN1),
        .clr   (st != ARB_OWN1),
        .cnt   (beats)
    );

    // Next-owner priority: locked burst, aged/unopposed m1, m0, idle.
    always_comb begin
        nxt_st = ARB_IDLE;
        if ((st == ARB_OWN1) && m1_req && m1_lock && (beats < BEAT_LIM)) begin
            nxt_st = ARB_OWN1;
        end else if (m1_req && (!m0_req || (wait1 >= WAIT_LIM))) begin
            nxt_st = ARB_OWN1;
        end else if (m0_req) begin
            nxt_st = ARB_OWN0;
        end else begin
            nxt_st = ARB_IDLE;
        end
    end

    // Ownership register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st <= ARB_IDLE;
        end else begin
            st <= nxt_st;
        end
    end

    // Bus mux: strobes only while the owner is actually requesting.
    always_comb begin
        bus_rd    = 1'b0;
        bus_wr    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        case (st)
            ARB_OWN0: begin
                bus_rd    = m0_req & ~m0_wr;
                bus_wr    = m0_req & m0_wr;
                bus_addr  = m0_addr;
                bus_wdata = m0_wdata;
            end
            ARB_OWN1: begin
                bus_rd    = m1_req & ~m1_wr;
                bus_wr    = m1_req & m1_wr;
                bus_addr  = m1_addr;
                bus_wdata = m1_wdata;
            end
            default: begin
                bus_rd    = 1'b0;
                bus_wr    = 1'b0;
                bus_addr  = '0;
                bus_wdata = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Self-checking bench for data_bus_arbiter with a 256-word memory model on the bus.
// Expected owners/data are queued from the scenario tables and popped per cycle.
module tb_data_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          m0_req, m0_wr, m1_req, m1_wr, m1_lock;
    logic [AW-1:0] m0_addr, m1_addr, bus_addr;
    logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, bus_wdata, bus_rdata;
    logic          m0_gnt, m1_gnt, bus_rd, bus_wr;
    logic [1:0]    owner;
    logic          mem_clr = 1'b1;
    logic [DW-1:0] mem [256];

    int            n_checks = 0;
    int            n_fail = 0;
    int            exp_owner_q[$];
    logic [DW-1:0] exp_data_q[$];

    always #5 clk = ~clk;

    data_bus_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4), .BURST_MAX(8)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_lock(m1_lock), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata),
        .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .owner(owner)
    );

    assign bus_rdata = bus_rd ? mem[bus_addr[7:0]] : '0;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (bus_wr) begin
            mem[bus_addr[7:0]] <= bus_wdata;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        m0_req = 1'b0; m0_wr = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_wr = 1'b0; m1_lock = 1'b0; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        mem_clr = 1'b1;
        step();
        mem_clr = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({m0_gnt, m1_gnt, owner, bus_rd, bus_wr, bus_addr, bus_wdata, m0_rdata, m1_rdata} !== '0)
            begin n_fail++; $display("FAIL reset_held: owner=%0d gnt=%b%b got nonzero outputs, expected all 0", owner, m0_gnt, m1_gnt); end
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            @(negedge clk);
            n_checks++;
            if ({m0_gnt, m1_gnt, owner, bus_rd, bus_wr, bus_addr, bus_wdata, m0_rdata, m1_rdata} !== '0)
                begin n_fail++; $display("FAIL reset_idle[%0d]: owner=%0d gnt=%b%b strobes=%b%b, expected all 0", c, owner, m0_gnt, m1_gnt, bus_rd, bus_wr); end
        end
    endtask

    task automatic test_single_write();
        bit got;
        logic [DW-1:0] exp;
        do_reset();
        m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF;
        @(negedge clk);
        n_checks++;
        if ({owner, bus_wr} !== 3'b000)
            begin n_fail++; $display("FAIL write_cycle1: owner=%0d bus_wr=%b, expected 0 0", owner, bus_wr); end
        step();
        @(negedge clk);
        n_checks++;
        if ({m0_gnt, bus_wr, bus_addr, bus_wdata} !== {1'b1, 1'b1, 32'h10, 32'hDEADBEEF})
            begin n_fail++; $display("FAIL write_cycle2: gnt=%b wr=%b addr=%h wdata=%h, expected 1 1 00000010 deadbeef", m0_gnt, bus_wr, bus_addr, bus_wdata); end
        step();
        m0_wr = 1'b0;
        exp_data_q.push_back(32'hDEADBEEF);
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            if (m0_gnt && bus_rd) begin
                got = 1'b1;
                exp = exp_data_q.pop_front();
                n_checks++;
                if (m0_rdata !== exp)
                    begin n_fail++; $display("FAIL readback: m0_rdata=%h, expected %h", m0_rdata, exp); end
                n_checks++;
                if (m1_rdata !== '0)
                    begin n_fail++; $display("FAIL m1_rdata_ungranted: m1_rdata=%h, expected 0", m1_rdata); end
            end else begin
                step();
            end
        end
        n_checks++;
        if (!got)
            begin n_fail++; $display("FAIL readback_timeout: no read beat within 4 cycles, expected one"); end
        step();
        idle_inputs();
    endtask

    task automatic test_release();
        do_reset();
        m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 32'h10;
        step();
        step();
        m0_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({m0_gnt, bus_rd, bus_wr} !== 3'b100)
            begin n_fail++; $display("FAIL release_no_strobe: gnt/rd/wr=%b, expected 100", {m0_gnt, bus_rd, bus_wr}); end
        step();
        @(negedge clk);
        n_checks++;
        if ({owner, m0_gnt, bus_rd, bus_wr} !== 5'b00000)
            begin n_fail++; $display("FAIL release_idle: owner=%0d gnt=%b rd=%b wr=%b, expected all 0", owner, m0_gnt, bus_rd, bus_wr); end
    endtask

    task automatic test_aging();
        int tbl [8] = '{0, 1, 1, 1, 1, 2, 1, 1};
        int e;
        do_reset();
        foreach (tbl[i]) exp_owner_q.push_back(tbl[i]);
        m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 32'h10;
        m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 32'h20;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) step();
            @(negedge clk);
            e = exp_owner_q.pop_front();
            n_checks++;
            if ({owner, m0_gnt, m1_gnt} !== {2'(e), (e == 1), (e == 2)})
                begin n_fail++; $display("FAIL aging_c%0d: owner=%0d gnt=%b%b, expected owner %0d", c, owner, m0_gnt, m1_gnt, e); end
            if (e == 2) begin
                n_checks++;
                if ({bus_rd, bus_addr} !== {1'b1, 32'h20})
                    begin n_fail++; $display("FAIL aging_m1_bus: rd=%b addr=%h, expected 1 00000020", bus_rd, bus_addr); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_locked_burst();
        int e;
        int beat = 0;
        int n_m1 = 0;
        bit prev_beat = 1'b0;
        do_reset();
        for (int c = 1; c <= 19; c++)
            exp_owner_q.push_back((c == 1) ? 0 : (c <= 5) ? 1 : (c <= 13) ? 2 : (c <= 18) ? 1 : 2);
        m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 32'h10;
        m1_req = 1'b1; m1_wr = 1'b1; m1_lock = 1'b1; m1_addr = 32'h40; m1_wdata = 32'h1000;
        for (int c = 1; c <= 19; c++) begin
            if (c > 1) begin
                step();
                if (prev_beat) begin
                    beat++;
                    m1_addr = 32'h40 + 32'(beat);
                    m1_wdata = 32'h1000 + 32'(beat);
                    if (beat == 12) m1_req = 1'b0;
                end
            end
            @(negedge clk);
            e = exp_owner_q.pop_front();
            n_checks++;
            if ({owner, m0_gnt, m1_gnt} !== {2'(e), (e == 1), (e == 2)})
                begin n_fail++; $display("FAIL burst_c%0d: owner=%0d gnt=%b%b, expected owner %0d", c, owner, m0_gnt, m1_gnt, e); end
            prev_beat = m1_gnt && m1_req;
            if (prev_beat) n_m1++;
        end
        n_checks++;
        if (n_m1 !== 9)
            begin n_fail++; $display("FAIL burst_beats: m1 beats=%0d, expected 9", n_m1); end
        step();
        n_checks++;
        if (mem[8'h47] !== 32'h1007)
            begin n_fail++; $display("FAIL burst_mem: mem[47]=%h, expected 00001007", mem[8'h47]); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        m1_req = 1'b1; m1_wr = 1'b1; m1_lock = 1'b1; m1_addr = 32'h40; m1_wdata = 32'hBAD00000;
        step();
        step();
        m1_addr = 32'h41; m1_wdata = 32'hBAD00001;
        step();
        m1_addr = 32'h42; m1_wdata = 32'hBAD00002;
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({m1_gnt, bus_wr, owner} !== 4'b0000)
            begin n_fail++; $display("FAIL rst_async: gnt=%b wr=%b owner=%0d, expected 0 0 0", m1_gnt, bus_wr, owner); end
        step();
        n_checks++;
        if ({mem[8'h41], mem[8'h42]} !== {32'hBAD00001, 32'h00001002})
            begin n_fail++; $display("FAIL rst_mem: mem[41]=%h mem[42]=%h, expected bad00001 00001002", mem[8'h41], mem[8'h42]); end
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({dut.wait1, dut.beats} !== 6'b000000)
            begin n_fail++; $display("FAIL rst_counters: wait1=%0d beats=%0d, expected 0 0", dut.wait1, dut.beats); end
        step();
        @(negedge clk);
        n_checks++;
        if ({m1_gnt, bus_wr, bus_addr} !== {1'b1, 1'b1, 32'h42})
            begin n_fail++; $display("FAIL rst_regrant: gnt=%b wr=%b addr=%h, expected 1 1 00000042", m1_gnt, bus_wr, bus_addr); end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_write();
        test_release();
        test_aging();
        test_locked_burst();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
